// File: rtl/ex_stage_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : ex_stage_if
// Brief  : Decode/execute/memory buses, data SRAM request and EX feedback.
// Rev    : 1.0  initial release
// ============================================================================
interface ex_stage_if #(
  parameter int ID_TO_EX_WD  = 159,
  parameter int EX_TO_MEM_WD = 76,
  parameter int STALL_WD     = 6
);
  logic [STALL_WD-1:0]     stall;
  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic                    data_sram_en;
  logic [3:0]              data_sram_wen;
  logic [31:0]             data_sram_addr;
  logic [31:0]             data_sram_wdata;
  logic                    ex_wreg;
  logic [4:0]              ex_waddr;
  logic [31:0]             ex_wdata;
  logic                    ex_opl;
  logic                    stallreq_ex;

  modport master (
    input  stall, id_to_ex_bus,
    output ex_to_mem_bus, data_sram_en, data_sram_wen, data_sram_addr,
           data_sram_wdata, ex_wreg, ex_waddr, ex_wdata, ex_opl, stallreq_ex
  );

  modport slave (
    output stall, id_to_ex_bus,
    input  ex_to_mem_bus, data_sram_en, data_sram_wen, data_sram_addr,
           data_sram_wdata, ex_wreg, ex_waddr, ex_wdata, ex_opl, stallreq_ex
  );
endinterface
`default_nettype wire

// File: rtl/ex_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : ex_stage
// Brief  : MIPS execute stage: ALU, store formatting, HI/LO and iterative
//          divider. Define EX_MULT_EN to run mult/multu on the same engine.
// Rev    : 1.0  initial release
// ============================================================================
module ex_stage #(
  parameter int ID_TO_EX_WD  = 159,
  parameter int EX_TO_MEM_WD = 76,
  parameter int STALL_WD     = 6
) (
  input  logic       clk,
  input  logic       rst,
  ex_stage_if.master bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  logic [ID_TO_EX_WD-1:0] r_id_to_ex_bus;
  logic [STALL_WD-1:0]    w_stall;
  logic [31:0] w_pc, w_inst, w_rdata1, w_rdata2;
  logic [11:0] w_alu_op;
  logic [2:0]  w_sel_src1;
  logic [3:0]  w_sel_src2, w_ram_wen;
  logic        w_ram_en, w_rf_we, w_sel_rf_res;
  logic [4:0]  w_rf_waddr;

  assign w_stall = bus.stall;

  always_ff @(posedge clk) begin
    if (rst)                          r_id_to_ex_bus <= '0;
    else if (w_stall[2] && !w_stall[3]) r_id_to_ex_bus <= '0;
    else if (!w_stall[2])             r_id_to_ex_bus <= bus.id_to_ex_bus;
  end

  assign {w_pc, w_inst, w_alu_op, w_sel_src1, w_sel_src2, w_ram_en, w_ram_wen,
          w_rf_we, w_rf_waddr, w_sel_rf_res, w_rdata1, w_rdata2} = r_id_to_ex_bus;

  logic [31:0] w_src1, w_src2, w_alu, w_result;
  assign w_src1 = ({32{w_sel_src1[0]}} & w_rdata1)
                | ({32{w_sel_src1[1]}} & w_pc)
                | ({32{w_sel_src1[2]}} & {27'b0, w_inst[10:6]});
  assign w_src2 = ({32{w_sel_src2[0]}} & w_rdata2)
                | ({32{w_sel_src2[1]}} & {{16{w_inst[15]}}, w_inst[15:0]})
                | ({32{w_sel_src2[2]}} & 32'd8)
                | ({32{w_sel_src2[3]}} & {16'b0, w_inst[15:0]});

  logic [31:0] w_sra;
  assign w_sra = $signed(w_src2) >>> w_src1[4:0];
  assign w_alu = ({32{w_alu_op[11]}} & (w_src1 + w_src2))
               | ({32{w_alu_op[10]}} & (w_src1 - w_src2))
               | ({32{w_alu_op[9]}}  & {31'b0, $signed(w_src1) < $signed(w_src2)})
               | ({32{w_alu_op[8]}}  & {31'b0, w_src1 < w_src2})
               | ({32{w_alu_op[7]}}  & (w_src1 & w_src2))
               | ({32{w_alu_op[6]}}  & ~(w_src1 | w_src2))
               | ({32{w_alu_op[5]}}  & (w_src1 | w_src2))
               | ({32{w_alu_op[4]}}  & (w_src1 ^ w_src2))
               | ({32{w_alu_op[3]}}  & (w_src2 << w_src1[4:0]))
               | ({32{w_alu_op[2]}}  & (w_src2 >> w_src1[4:0]))
               | ({32{w_alu_op[1]}}  & w_sra)
               | ({32{w_alu_op[0]}}  & {w_src2[15:0], 16'b0});

  logic w_special, w_is_div, w_is_divu, w_is_mult, w_is_multu;
  logic w_is_mfhi, w_is_mflo, w_is_mthi, w_is_mtlo;
  assign w_special  = (w_inst[31:26] == 6'b000000);
  assign w_is_div   = w_special && (w_inst[5:0] == 6'b011010);
  assign w_is_divu  = w_special && (w_inst[5:0] == 6'b011011);
  assign w_is_mult  = w_special && (w_inst[5:0] == 6'b011000);
  assign w_is_multu = w_special && (w_inst[5:0] == 6'b011001);
  assign w_is_mfhi  = w_special && (w_inst[5:0] == 6'b010000);
  assign w_is_mflo  = w_special && (w_inst[5:0] == 6'b010010);
  assign w_is_mthi  = w_special && (w_inst[5:0] == 6'b010001);
  assign w_is_mtlo  = w_special && (w_inst[5:0] == 6'b010011);

  logic [31:0] r_hi, r_lo;
  assign w_result = w_is_mfhi ? r_hi : (w_is_mflo ? r_lo : w_alu);

  logic [3:0]  w_wen;
  logic [31:0] w_wdata;
  always_comb begin
    w_wen   = 4'b0000;
    w_wdata = 32'b0;
    case (w_ram_wen)
      4'b1111: begin w_wen = 4'b1111;                       w_wdata = w_rdata2;             end
      4'b0001: begin w_wen = 4'b0001 << w_alu[1:0];         w_wdata = {4{w_rdata2[7:0]}};   end
      4'b0011: begin w_wen = 4'b0011 << {w_alu[1], 1'b0};   w_wdata = {2{w_rdata2[15:0]}};  end
      default: ;
    endcase
  end

  logic [EX_TO_MEM_WD-1:0] w_ex_to_mem_bus;
  assign w_ex_to_mem_bus     = {w_pc, w_ram_en, w_ram_wen, w_sel_rf_res, w_rf_we, w_rf_waddr, w_result};
  assign bus.ex_to_mem_bus   = w_ex_to_mem_bus;
  assign bus.data_sram_en    = w_ram_en;
  assign bus.data_sram_wen   = w_wen;
  assign bus.data_sram_addr  = w_alu;
  assign bus.data_sram_wdata = w_wdata;
  assign bus.ex_wreg         = w_rf_we;
  assign bus.ex_waddr        = w_rf_waddr;
  assign bus.ex_wdata        = w_result;
  assign bus.ex_opl          = w_sel_rf_res;

  logic w_is_mul;
`ifdef EX_MULT_EN
  assign w_is_mul = w_is_mult | w_is_multu;
`else
  logic w_mul_unused;
  assign w_mul_unused = w_is_mult | w_is_multu;
  assign w_is_mul     = 1'b0;
`endif

  logic w_start, w_signed;
  logic [31:0] w_abs1, w_abs2;
  assign w_start  = w_is_div | w_is_divu | w_is_mul;
  assign w_signed = w_is_div | w_is_mult;
  assign w_abs1   = (w_signed && w_rdata1[31]) ? (32'd0 - w_rdata1) : w_rdata1;
  assign w_abs2   = (w_signed && w_rdata2[31]) ? (32'd0 - w_rdata2) : w_rdata2;

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_cnt;
  logic [31:0] r_acc_hi, r_acc_lo, r_opnd, r_dz_hi;
  logic        r_is_mul, r_neg_q, r_neg_r, r_dz;
  logic        w_stallreq, w_commit;

  always_comb begin
    w_state_nxt = r_state;
    w_stallreq  = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: if (w_start) begin
        w_state_nxt = S_RUN;
        w_stallreq  = 1'b1;
      end
      S_RUN: begin
        w_stallreq = 1'b1;
        if (r_cnt == 5'd31) w_state_nxt = S_DONE;
      end
      S_DONE: if (!w_stall[3]) begin
        w_commit    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end
  assign bus.stallreq_ex = w_stallreq;

  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  // Multiply: acc_hi accumulates, acc_lo shifts the multiplier out and product low in.
  logic [32:0] w_part, w_diff, w_sum;
  assign w_part = {r_acc_hi, r_acc_lo[31]};
  assign w_diff = w_part - {1'b0, r_opnd};
  assign w_sum  = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : 33'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 5'd0;
      r_acc_hi <= 32'd0;
      r_acc_lo <= 32'd0;
      r_opnd   <= 32'd0;
      r_dz_hi  <= 32'd0;
      r_is_mul <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_start) begin
        r_cnt    <= 5'd0;
        r_is_mul <= w_is_mul;
        r_neg_q  <= w_signed & (w_rdata1[31] ^ w_rdata2[31]);
        r_neg_r  <= w_signed & w_rdata1[31];
        r_dz     <= !w_is_mul && (w_rdata2 == 32'd0);
        r_dz_hi  <= w_rdata1;
        r_opnd   <= w_is_mul ? w_abs1 : w_abs2;
        r_acc_hi <= 32'd0;
        r_acc_lo <= w_is_mul ? w_abs2 : w_abs1;
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt + 5'd1;
        if (r_is_mul)      {r_acc_hi, r_acc_lo} <= {w_sum, r_acc_lo[31:1]};
        else if (!w_diff[32]) {r_acc_hi, r_acc_lo} <= {w_diff[31:0], r_acc_lo[30:0], 1'b1};
        else               {r_acc_hi, r_acc_lo} <= {w_part[31:0], r_acc_lo[30:0], 1'b0};
      end
    end
  end

  logic [63:0] w_prod, w_hilo_new;
  logic [31:0] w_quo, w_rem;
  assign w_prod = r_neg_q ? (64'd0 - {r_acc_hi, r_acc_lo}) : {r_acc_hi, r_acc_lo};
  assign w_quo  = r_neg_q ? (32'd0 - r_acc_lo) : r_acc_lo;
  assign w_rem  = r_neg_r ? (32'd0 - r_acc_hi) : r_acc_hi;
  assign w_hilo_new = r_is_mul ? w_prod :
                      r_dz     ? {r_dz_hi, 32'hFFFF_FFFF} : {w_rem, w_quo};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_commit) begin
      r_hi <= w_hilo_new[63:32];
      r_lo <= w_hilo_new[31:0];
    end else begin
      if (w_is_mthi) r_hi <= w_rdata1;
      if (w_is_mtlo) r_lo <= w_rdata1;
    end
  end

  logic w_unused;
  assign w_unused = ^{w_stall[STALL_WD-1:4], w_stall[1:0], w_inst[25:16]};
endmodule
`default_nettype wire
